// File: rtl/vend_pkg.sv
// Shared types and constants for the coffee vending sequencer.
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StDispense,
        StChange,
        StRefund
    } vend_state_t;

    localparam int unsigned COIN_1  = 1;
    localparam int unsigned COIN_2  = 2;
    localparam int unsigned COIN_5  = 5;
    localparam int unsigned COIN_10 = 10;

    localparam int unsigned DEFAULT_PRICE = 10;

endpackage

// File: rtl/vend_timer.sv
// Cycle timer with synchronous clear; done flags the enabled cycle that completes TC counts.
module vend_timer #(
    parameter int unsigned TC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int unsigned W = $clog2(TC + 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted on the enabled cycle whose edge would complete the TC-th count.
    assign done = enable && !clear && (count_q == W'(TC - 1));

endmodule

// File: rtl/vend_sequencer.sv
// Vending controller: coin credit accumulation, dispenser handshake, change/refund payout, LEDs.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned PRICE       = DEFAULT_PRICE,
    parameter int unsigned COIN_W      = 4,
    parameter int unsigned CREDIT_W    = 5,
    parameter int unsigned IDLE_TO_CYC = 1000,
    parameter int unsigned DISP_TO_CYC = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_val,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_accept,
    output logic [CREDIT_W-1:0] credit,
    output logic                led_green,
    output logic                led_yellow,
    output logic                fault
);

    // Largest reachable credit is PRICE-1 plus the biggest coin; it must not wrap.
    if ((PRICE - 1) + ((1 << COIN_W) - 1) >= (1 << CREDIT_W)) begin : g_credit_w_check
        $error("vend_sequencer: CREDIT_W too narrow for PRICE and COIN_W");
    end

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
    logic                fault_q, fault_d;

    logic                coin_ok;
    logic [CREDIT_W-1:0] credit_sum;
    logic                idle_clear, idle_en, idle_done;
    logic                disp_clear, disp_en, disp_done;

    assign coin_ok    = coin_valid && (coin_val != '0);
    assign credit_sum = credit_q + CREDIT_W'(coin_val);

    vend_timer #(
        .TC (IDLE_TO_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (idle_clear),
        .enable (idle_en),
        .done   (idle_done)
    );

    vend_timer #(
        .TC (DISP_TO_CYC)
    ) u_disp_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (disp_clear),
        .enable (disp_en),
        .done   (disp_done)
    );

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        change_amt_d = change_amt_q;
        fault_d      = fault_q;
        idle_clear   = 1'b1;
        idle_en      = 1'b0;
        disp_clear   = 1'b1;
        disp_en      = 1'b0;

        case (state_q)
            StIdle: begin
                if (coin_ok) begin
                    credit_d = credit_sum;
                    state_d  = (credit_sum >= CREDIT_W'(PRICE)) ? StDispense : StCollect;
                end
            end
            StCollect: begin
                idle_clear = coin_ok;
                idle_en    = !coin_ok;
                if (coin_ok) begin
                    credit_d = credit_sum;
                end
                // Cancel outranks reaching the price: the coin is refunded with the rest.
                if (cancel || idle_done) begin
                    state_d = StRefund;
                end else if (coin_ok && (credit_sum >= CREDIT_W'(PRICE))) begin
                    state_d = StDispense;
                end
            end
            StDispense: begin
                disp_clear = 1'b0;
                disp_en    = 1'b1;
                if (disp_ack) begin
                    if (credit_q > CREDIT_W'(PRICE)) begin
                        state_d = StChange;
                    end else begin
                        state_d  = StIdle;
                        credit_d = '0;
                    end
                end else if (disp_done) begin
                    fault_d = 1'b1;
                    state_d = StRefund;
                end
            end
            StChange, StRefund: begin
                state_d  = StIdle;
                credit_d = '0;
            end
            default: begin
                state_d  = StIdle;
                credit_d = '0;
            end
        endcase

        // Load the payout register on entry so it is valid during the one-cycle payout state.
        if (state_d == StChange && state_q != StChange) begin
            change_amt_d = credit_d - CREDIT_W'(PRICE);
        end else if (state_d == StRefund && state_q != StRefund) begin
            change_amt_d = credit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            credit_q     <= '0;
            change_amt_q <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            change_amt_q <= change_amt_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        disp_req     = (state_q == StDispense);
        change_valid = (state_q == StChange) || (state_q == StRefund);
        coin_accept  = (state_q == StIdle) || (state_q == StCollect);
        led_green    = (state_q == StIdle);
        led_yellow   = (state_q == StDispense) || (state_q == StChange) || (state_q == StRefund);
    end

    assign change_amt = change_amt_q;
    assign credit     = credit_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: coin sequences, timeouts, cancel, fault and reset abort.
module tb_vend_sequencer;
    import vend_pkg::*;

    localparam int unsigned COIN_W   = 4;
    localparam int unsigned CREDIT_W = 5;
    localparam int unsigned IDLE_TO  = 1000;
    localparam int unsigned DISP_TO  = 500;

    logic                clk = 1'b0;
    logic                rst;
    logic                coin_valid;
    logic [COIN_W-1:0]   coin_val;
    logic                cancel;
    logic                disp_req;
    logic                disp_ack;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic                coin_accept;
    logic [CREDIT_W-1:0] credit;
    logic                led_green;
    logic                led_yellow;
    logic                fault;

    int n_checks = 0;
    int n_fail   = 0;

    vend_sequencer #(
        .PRICE       (10),
        .COIN_W      (COIN_W),
        .CREDIT_W    (CREDIT_W),
        .IDLE_TO_CYC (IDLE_TO),
        .DISP_TO_CYC (DISP_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .cancel       (cancel),
        .disp_req     (disp_req),
        .disp_ack     (disp_ack),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .coin_accept  (coin_accept),
        .credit       (credit),
        .led_green    (led_green),
        .led_yellow   (led_yellow),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int unsigned v);
        coin_valid = 1'b1;
        coin_val   = COIN_W'(v);
        step();
        coin_valid = 1'b0;
        coin_val   = '0;
    endtask

    task automatic ack();
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; coin_valid = 1'b0; coin_val = '0; cancel = 1'b0; disp_ack = 1'b0;
        #2;
        do_reset();

        check_eq("rst_green", int'(led_green), 1);
        check_eq("rst_accept", int'(coin_accept), 1);
        check_eq("rst_credit", int'(credit), 0);
        check_eq("rst_req", int'(disp_req), 0);
        check_eq("rst_cv", int'(change_valid), 0);
        check_eq("rst_yellow", int'(led_yellow), 0);
        check_eq("rst_fault", int'(fault), 0);

        // Zero-value coin and a stray ack in IDLE are ignored
        coin(0);
        check_eq("zero_coin_credit", int'(credit), 0);
        check_eq("zero_coin_green", int'(led_green), 1);
        ack();
        check_eq("stray_ack_green", int'(led_green), 1);

        // 1: 5,2,5 -> 12, change 2
        coin(COIN_5);
        check_eq("t1_credit5", int'(credit), 5);
        check_eq("t1_green_off", int'(led_green), 0);
        coin(COIN_2);
        check_eq("t1_credit7", int'(credit), 7);
        coin(COIN_5);
        check_eq("t1_credit12", int'(credit), 12);
        check_eq("t1_req", int'(disp_req), 1);
        check_eq("t1_accept_off", int'(coin_accept), 0);
        check_eq("t1_yellow", int'(led_yellow), 1);
        ack();
        check_eq("t1_cv", int'(change_valid), 1);
        check_eq("t1_amt", int'(change_amt), 2);
        step();
        check_eq("t1_idle_green", int'(led_green), 1);
        check_eq("t1_cv_off", int'(change_valid), 0);
        check_eq("t1_credit0", int'(credit), 0);
        check_eq("t1_amt_hold", int'(change_amt), 2);

        // 2: exact price, no change
        coin(COIN_10);
        check_eq("t2_req", int'(disp_req), 1);
        check_eq("t2_credit", int'(credit), 10);
        ack();
        check_eq("t2_green", int'(led_green), 1);
        check_eq("t2_cv", int'(change_valid), 0);
        check_eq("t2_credit0", int'(credit), 0);

        // 3: idle timeout refund
        coin(COIN_5);
        repeat (IDLE_TO - 1) step();
        check_eq("t3_still_collect", int'(coin_accept & ~led_green), 1);
        check_eq("t3_no_cv_early", int'(change_valid), 0);
        step();
        check_eq("t3_cv", int'(change_valid), 1);
        check_eq("t3_amt", int'(change_amt), 5);
        step();
        check_eq("t3_green", int'(led_green), 1);
        check_eq("t3_credit0", int'(credit), 0);

        // 4: coin + cancel same cycle, then coin during DISPENSE
        coin(COIN_2);
        cancel = 1'b1;
        coin(COIN_5);
        cancel = 1'b0;
        check_eq("t4_cv", int'(change_valid), 1);
        check_eq("t4_amt", int'(change_amt), 7);
        step();
        coin(COIN_10);
        coin(COIN_5);
        check_eq("t4_disp_credit", int'(credit), 10);
        check_eq("t4_disp_req", int'(disp_req), 1);
        ack();
        check_eq("t4_credit0", int'(credit), 0);

        // 5a: dispense timeout -> fault refund
        coin(COIN_10);
        repeat (DISP_TO - 1) step();
        check_eq("t5_req_before_to", int'(disp_req), 1);
        check_eq("t5_fault_before_to", int'(fault), 0);
        step();
        check_eq("t5_fault", int'(fault), 1);
        check_eq("t5_cv", int'(change_valid), 1);
        check_eq("t5_amt", int'(change_amt), 10);
        step();
        check_eq("t5_fault_sticky", int'(fault), 1);
        check_eq("t5_green", int'(led_green), 1);

        // 6: reset mid-dispense with credit 12 (also clears the sticky fault)
        coin(COIN_5);
        coin(7);
        check_eq("t6_req", int'(disp_req), 1);
        check_eq("t6_credit", int'(credit), 12);
        do_reset();
        check_eq("t6_green", int'(led_green), 1);
        check_eq("t6_credit0", int'(credit), 0);
        check_eq("t6_req_off", int'(disp_req), 0);
        check_eq("t6_cv", int'(change_valid), 0);
        check_eq("t6_fault", int'(fault), 0);

        // 5b: ack on the timeout cycle wins
        coin(COIN_10);
        repeat (DISP_TO - 1) step();
        ack();
        check_eq("t5b_fault", int'(fault), 0);
        check_eq("t5b_green", int'(led_green), 1);
        check_eq("t5b_cv", int'(change_valid), 0);
        check_eq("t5b_credit0", int'(credit), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
